// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data-memory arbiter.
package mem_pkg;
  localparam int DW = 32;
  typedef enum logic [1:0] {S_CPU, S_DMA, S_LOCK} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_D} owner_t;
endpackage

// File: rtl/arb_rr_guard.sv
// arb_rr_guard: CPU-priority grant decode with DMA starvation guard and lock.
module arb_rr_guard
  import mem_pkg::*;
#(
  parameter int MAX_CPU_RUN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic c_req,
  input  logic d_req,
  input  logic d_lock,
  output logic c_gnt,
  output logic d_gnt
);
  localparam logic [3:0] MAX = 4'(MAX_CPU_RUN);
  arb_state_t state;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  always_comb begin
    c_gnt = (state == S_CPU) ? c_req : (state == S_DMA) ? c_req & ~d_req : 1'b0;
    d_gnt = (state == S_CPU) ? d_req & ~c_req : d_req;
    cnt_inc = (cnt == MAX) ? cnt : cnt + 4'd1;
  end
  // reaching MAX on a CPU grant hands the very next cycle to the DMA
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CPU;
      cnt <= '0;
    end else begin
      case (state)
        S_CPU: begin
          if (d_gnt) begin
            cnt <= '0;
            state <= d_lock ? S_LOCK : S_CPU;
          end else if (!d_req) cnt <= '0;
          else if (c_gnt) begin
            cnt <= cnt_inc;
            if (cnt_inc == MAX) state <= S_DMA;
          end
        end
        S_DMA: begin
          cnt <= '0;
          state <= (d_gnt && d_lock) ? S_LOCK : S_CPU;
        end
        S_LOCK: begin
          cnt <= '0;
          if (!d_lock) state <= S_CPU;
        end
        default: state <= S_CPU;
      endcase
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the RAM data port between CPU and DMA with tagged read return.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int AW = 14,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          C_REQ,
  input  logic          C_WE,
  input  logic [3:0]    C_BE,
  input  logic [AW-1:0] C_ADDR,
  input  logic [DW-1:0] C_WD,
  output logic          C_GNT,
  output logic          C_RVALID,
  output logic [DW-1:0] C_RD,
  input  logic          D_REQ,
  input  logic          D_WE,
  input  logic [3:0]    D_BE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WD,
  input  logic          D_LOCK,
  output logic          D_GNT,
  output logic          D_RVALID,
  output logic [DW-1:0] D_RD,
  output logic [AW-1:0] M_ADDR,
  output logic          M_WE,
  output logic [3:0]    M_BE,
  output logic [DW-1:0] M_WD,
  input  logic [DW-1:0] M_RD
);
  owner_t owner;
  logic [DW-1:0] c_hold;
  logic [DW-1:0] d_hold;
  arb_rr_guard #(.MAX_CPU_RUN(MAX_CPU_RUN)) u_guard (
    .clk(CLK),
    .rst_n(RESET),
    .c_req(C_REQ),
    .d_req(D_REQ),
    .d_lock(D_LOCK),
    .c_gnt(C_GNT),
    .d_gnt(D_GNT)
  );
  always_comb begin
    M_ADDR = D_GNT ? D_ADDR : C_ADDR;
    M_BE = D_GNT ? D_BE : C_BE;
    M_WD = D_GNT ? D_WD : C_WD;
    M_WE = (C_GNT & C_WE) | (D_GNT & D_WE);
    C_RVALID = (owner == OWN_C);
    D_RVALID = (owner == OWN_D);
    C_RD = C_RVALID ? M_RD : c_hold;
    D_RD = D_RVALID ? M_RD : d_hold;
  end
  // holds keep the last delivered word so a non-owner's RD stays put
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      owner <= OWN_NONE;
      c_hold <= '0;
      d_hold <= '0;
    end else begin
      owner <= (C_GNT & ~C_WE) ? OWN_C : (D_GNT & ~D_WE) ? OWN_D : OWN_NONE;
      c_hold <= C_RD;
      d_hold <= D_RD;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table with hand-written grants plus read-return scoreboard.
module tb_dmem_arbiter;
  localparam int AW = 14;
  typedef struct {
    logic cr, cw; logic [3:0] cb; logic [13:0] ca; logic [31:0] cd;
    logic dr, dw; logic [3:0] db; logic [13:0] da; logic [31:0] dd;
    logic dl, ec, ed;
  } vec_t;
  typedef struct {logic [1:0] own; logic [31:0] data;} sb_t;
  logic CLK = 0, RESET = 0, init = 1;
  logic C_REQ, C_WE, C_GNT, C_RVALID, D_REQ, D_WE, D_LOCK, D_GNT, D_RVALID, M_WE;
  logic [3:0] C_BE, D_BE, M_BE;
  logic [AW-1:0] C_ADDR, D_ADDR, M_ADDR;
  logic [31:0] C_WD, D_WD, C_RD, D_RD, M_WD, m_rd;
  logic [31:0] mem [0:2**AW-1];
  logic [31:0] ref_mem [0:2**AW-1];
  vec_t v[$];
  sb_t sb[$];
  int cmp = 0, err = 0;
  logic [31:0] lc, ld;
  logic hc = 0, hd = 0;

  dmem_arbiter #(.AW(AW), .MAX_CPU_RUN(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .C_REQ(C_REQ), .C_WE(C_WE), .C_BE(C_BE), .C_ADDR(C_ADDR), .C_WD(C_WD),
    .C_GNT(C_GNT), .C_RVALID(C_RVALID), .C_RD(C_RD),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WD(D_WD),
    .D_LOCK(D_LOCK), .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RD(D_RD),
    .M_ADDR(M_ADDR), .M_WE(M_WE), .M_BE(M_BE), .M_WD(M_WD), .M_RD(m_rd)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (init) begin
      mem[14'h010] <= 32'hCAFEF00D;
      mem[14'h004] <= 32'h0000000A;
      mem[14'h008] <= 32'h0000000B;
      mem[14'h100] <= '0;
      mem[14'h101] <= '0;
      mem[14'h102] <= '0;
      mem[14'h200] <= '0;
    end else if (M_WE) begin
      for (int b = 0; b < 4; b++) if (M_BE[b]) mem[M_ADDR][8*b +: 8] <= M_WD[8*b +: 8];
    end
    m_rd <= mem[M_ADDR];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic cr, logic cw, logic [3:0] cb, logic [13:0] ca, logic [31:0] cd,
                              logic dr, logic dw, logic [3:0] db, logic [13:0] da, logic [31:0] dd,
                              logic dl, logic ec, logic ed);
    vec_t x;
    x.cr = cr; x.cw = cw; x.cb = cb; x.ca = ca; x.cd = cd;
    x.dr = dr; x.dw = dw; x.db = db; x.da = da; x.dd = dd;
    x.dl = dl; x.ec = ec; x.ed = ed;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    C_REQ = x.cr; C_WE = x.cw; C_BE = x.cb; C_ADDR = x.ca; C_WD = x.cd;
    D_REQ = x.dr; D_WE = x.dw; D_BE = x.db; D_ADDR = x.da; D_WD = x.dd; D_LOCK = x.dl;
  endtask

  task automatic pop_check(input int i);
    sb_t e;
    e = sb.pop_front();
    chk($sformatf("c_rvalid[%0d]", i), {31'd0, C_RVALID}, {31'd0, e.own == 2'd1});
    chk($sformatf("d_rvalid[%0d]", i), {31'd0, D_RVALID}, {31'd0, e.own == 2'd2});
    if (e.own == 2'd1) begin
      chk($sformatf("c_rd[%0d]", i), C_RD, e.data);
      lc = e.data; hc = 1;
    end else if (hc) chk($sformatf("c_rd_hold[%0d]", i), C_RD, lc);
    if (e.own == 2'd2) begin
      chk($sformatf("d_rd[%0d]", i), D_RD, e.data);
      ld = e.data; hd = 1;
    end else if (hd) chk($sformatf("d_rd_hold[%0d]", i), D_RD, ld);
  endtask

  initial begin
    vec_t idle, x;
    sb_t e;
    for (int a = 0; a < 2**AW; a++) ref_mem[a] = '0;
    ref_mem[14'h010] = 32'hCAFEF00D;
    ref_mem[14'h004] = 32'h0000000A;
    ref_mem[14'h008] = 32'h0000000B;
    idle = mk(0, 0, 4'hF, 14'h000, 0, 0, 0, 4'hF, 14'h000, 0, 0, 0, 0);
    v.push_back(mk(1, 0, 4'hF, 14'h010, 0, 0, 0, 4'hF, 14'h000, 0, 0, 1, 0));
    v.push_back(idle);
    v.push_back(mk(1, 0, 4'hF, 14'h004, 0, 0, 0, 4'hF, 14'h000, 0, 0, 1, 0));
    v.push_back(mk(0, 0, 4'hF, 14'h004, 0, 1, 0, 4'hF, 14'h008, 0, 0, 0, 1));
    v.push_back(idle);
    for (int i = 0; i < 10; i++)
      v.push_back(mk(1, 0, 4'hF, 14'h010, 0, 1, 0, 4'hF, 14'h004, 0, 0, i % 5 != 4, i % 5 == 4));
    v.push_back(idle);
    for (int i = 0; i < 5; i++)
      v.push_back(mk(1, 0, 4'hF, 14'h010, 0, 1, 1, 4'hF, 14'h100, 32'h11, 1, i < 4, i == 4));
    v.push_back(mk(1, 0, 4'hF, 14'h010, 0, 1, 1, 4'hF, 14'h101, 32'h22, 1, 0, 1));
    v.push_back(mk(1, 0, 4'hF, 14'h010, 0, 1, 1, 4'hF, 14'h102, 32'h33, 1, 0, 1));
    v.push_back(mk(1, 0, 4'hF, 14'h010, 0, 0, 0, 4'hF, 14'h000, 0, 1, 0, 0));
    v.push_back(mk(1, 0, 4'hF, 14'h010, 0, 0, 0, 4'hF, 14'h000, 0, 0, 0, 0));
    v.push_back(mk(1, 0, 4'hF, 14'h101, 0, 0, 0, 4'hF, 14'h000, 0, 0, 1, 0));
    v.push_back(idle);
    for (int i = 0; i < 4; i++)
      v.push_back(mk(1, 0, 4'hF, 14'h004, 0, 1, 0, 4'hF, 14'h008, 0, 0, 1, 0));
    v.push_back(mk(1, 0, 4'hF, 14'h004, 0, 0, 0, 4'hF, 14'h008, 0, 0, 1, 0));
    v.push_back(mk(1, 0, 4'hF, 14'h004, 0, 1, 0, 4'hF, 14'h008, 0, 0, 1, 0));
    v.push_back(mk(1, 1, 4'b0011, 14'h200, 32'hDEADBEEF, 0, 0, 4'hF, 14'h000, 0, 0, 1, 0));
    v.push_back(mk(1, 0, 4'hF, 14'h200, 0, 0, 0, 4'hF, 14'h000, 0, 0, 1, 0));
    v.push_back(idle);

    drive(v[0]);
    repeat (2) begin
      @(negedge CLK);
      chk("rst_c_rvalid", {31'd0, C_RVALID}, 32'd0);
      chk("rst_d_rvalid", {31'd0, D_RVALID}, 32'd0);
      chk("rst_c_gnt", {31'd0, C_GNT}, 32'd1);
    end
    RESET = 1;
    init = 0;
    for (int i = 0; i < v.size(); i++) begin
      x = v[i];
      drive(x);
      #1;
      chk($sformatf("c_gnt[%0d]", i), {31'd0, C_GNT}, {31'd0, x.ec});
      chk($sformatf("d_gnt[%0d]", i), {31'd0, D_GNT}, {31'd0, x.ed});
      chk($sformatf("m_we[%0d]", i), {31'd0, M_WE}, {31'd0, (x.ec & x.cw) | (x.ed & x.dw)});
      chk($sformatf("m_addr[%0d]", i), {18'd0, M_ADDR}, {18'd0, x.ed ? x.da : x.ca});
      e.own = 2'd0;
      e.data = '0;
      if (x.ec && x.cw) begin
        for (int b = 0; b < 4; b++) if (x.cb[b]) ref_mem[x.ca][8*b +: 8] = x.cd[8*b +: 8];
      end else if (x.ed && x.dw) begin
        for (int b = 0; b < 4; b++) if (x.db[b]) ref_mem[x.da][8*b +: 8] = x.dd[8*b +: 8];
      end else if (x.ec) begin
        e.own = 2'd1; e.data = ref_mem[x.ca];
      end else if (x.ed) begin
        e.own = 2'd2; e.data = ref_mem[x.da];
      end
      sb.push_back(e);
      @(negedge CLK);
      pop_check(i);
    end

    drive(mk(1, 0, 4'hF, 14'h004, 0, 0, 0, 4'hF, 14'h000, 0, 0, 1, 0));
    #1 chk("mid_c_gnt", {31'd0, C_GNT}, 32'd1);
    #2 RESET = 0;
    #1 chk("mid_m_we", {31'd0, M_WE}, 32'd0);
    @(negedge CLK);
    chk("mid_c_rvalid_rst", {31'd0, C_RVALID}, 32'd0);
    chk("mid_m_we_rst", {31'd0, M_WE}, 32'd0);
    drive(idle);
    RESET = 1;
    @(negedge CLK);
    chk("mid_c_rvalid_rel", {31'd0, C_RVALID}, 32'd0);
    chk("mid_d_rvalid_rel", {31'd0, D_RVALID}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data port of the on-chip RAM between two requesters: the CPU data port (C_*) and a DMA/boot-loader port (D_*).
- Sits between the core's memory interface and the RAM data port. The instruction port is not arbitrated.
- Fixed CPU priority, with a starvation guard that forces a DMA grant after a bounded CPU run, plus a DMA lock for uninterrupted bursts.
- Returns read data one cycle after grant, tagged to the requester that owned the access.

Parameters:
- AW, 14: word address width (RAM depth 2^AW words).
- MAX_CPU_RUN, 4: maximum consecutive CPU grants while DMA is waiting (range 1..15).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- C_REQ  in  1  CPU access request.
- C_WE  in  1  CPU write enable (0 = read).
- C_BE  in  4  CPU byte enables.
- C_ADDR  in  AW  CPU word address.
- C_WD  in  32  CPU write data.
- C_GNT  out  1  CPU access accepted this cycle (combinational).
- C_RVALID  out  1  CPU read data valid (registered).
- C_RD  out  32  CPU read data.
- D_REQ, D_WE, D_BE, D_ADDR, D_WD  in  1/1/4/AW/32  DMA request bundle, same meaning as the CPU bundle.
- D_LOCK  in  1  DMA holds ownership while asserted.
- D_GNT  out  1  DMA access accepted this cycle.
- D_RVALID  out  1  DMA read data valid.
- D_RD  out  32  DMA read data.
- M_ADDR  out  AW  RAM data address.
- M_WE  out  1  RAM write enable.
- M_BE  out  4  RAM byte enables.
- M_WD  out  32  RAM write data.
- M_RD  in  32  RAM read data; valid the cycle after the address is presented.

Behaviour:
- Reset (RESET=0, async):
  - state=S_CPU, run counter=0, rd_owner pipe=NONE.
  - C_RVALID=0, D_RVALID=0.
  - GNTs are combinational but evaluated with the reset state.
- Grant is same-cycle: at most one of C_GNT/D_GNT is high. A GNT=1 cycle is a completed request (no retry). A requester with GNT=0 holds its bundle stable until granted.
- RAM mux:
  - M_* driven from the granted bundle.
  - No grant: M_ADDR=C_ADDR, M_BE=C_BE, M_WD=C_WD, M_WE=0.
  - M_WE = grant & WE of the owner.
- States:
  - S_CPU:
    - C_REQ wins. D wins only if C_REQ=0.
    - Counter increments on each C grant while D_REQ=1. It clears when D_REQ=0 or when D is granted.
    - counter==MAX_CPU_RUN with D_REQ=1 -> S_DMA (next-cycle grant goes to D).
    - D granted with D_LOCK=1 -> S_LOCK.
  - S_DMA:
    - D_REQ wins. C wins only if D_REQ=0.
    - After one D grant: D_LOCK=1 -> S_LOCK, else -> S_CPU (counter=0).
    - D_REQ drops before grant -> S_CPU.
  - S_LOCK:
    - Only D may be granted. C_GNT=0 even if D_REQ=0 (bubble).
    - D_LOCK=0 -> S_CPU, counter=0. D_REQ=0 alone does not release the lock.
- Read return:
  - rd_owner register = C, D, or NONE, loaded from the cycle's grant with WE=0.
  - Next cycle: the owner's RVALID=1 and its RD=M_RD.
  - Non-owner RD holds its last value; RVALID=0.
  - Writes produce no RVALID.
- Back-to-back:
  - C read in cycle n, D read in cycle n+1: C_RVALID at n+1, D_RVALID at n+2. No loss.
- Simultaneous C_REQ and D_REQ in S_CPU with counter<MAX: C wins.
- Reset asserted mid-read: pending RVALID is dropped (not delivered after reset release).
- Counter width 4 bits, saturates at MAX_CPU_RUN, never wraps.

Decomposition:
- Shared package mem_pkg:
  - arb_state_t enum {S_CPU, S_DMA, S_LOCK}.
  - owner_t enum {OWN_NONE, OWN_C, OWN_D}.
  - Word width constant DW=32.
- One sub-module, arb_rr_guard: state register, run counter and grant decode.
- Top level holds the M_* mux and the read-return pipe.

Test Plan:
- Reset: RESET=0 with C_REQ=1, then release -> C_RVALID=D_RVALID=0 during reset; first edge after release grants C.
- CPU-only read: C_REQ=1, C_WE=0, C_ADDR=0x010, RAM word 0x010=0xCAFEF00D -> C_GNT=1 same cycle; C_RVALID=1 next cycle with C_RD=0xCAFEF00D; D_RVALID=0.
- Starvation guard: C_REQ and D_REQ both held high, MAX_CPU_RUN=4 -> grants C,C,C,C,D,C,C,C,C,D...
- Lock burst: D writes 0x11,0x22,0x33 to addresses 0x100..0x102 with D_LOCK=1 while C_REQ=1 -> C_GNT=0 for the whole burst; lock released -> C granted next cycle; CPU readback of 0x101 returns 0x00000022.
- Interleaved reads: C reads 0x004 (=0xA) in cycle n, D reads 0x008 (=0xB) in cycle n+1 -> C_RVALID at n+1 with 0xA; D_RVALID at n+2 with 0xB.
- Reset mid-read: C read granted, then RESET=0 before the next edge -> C_RVALID stays 0; M_WE=0 throughout.
